// File: rtl/fb_write_scheduler.sv
// Round-robin merge of pixel-write sources into a show-ahead FIFO drained during blanking.
// Optional hiwater/stall_cnt statistics when FB_WR_STATS_EN is defined.
module fb_write_scheduler #(
  parameter int NUM_SRC    = 3,
  parameter int HPOS_WIDTH = 10,
  parameter int VPOS_WIDTH = 10,
  parameter int RGB_WIDTH  = 3,
  parameter int DEPTH      = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             display_on,
  input  logic [HPOS_WIDTH-1:0]            hpos,
  input  logic [VPOS_WIDTH-1:0]            vpos,
  input  logic [NUM_SRC-1:0]               src_valid,
  output logic [NUM_SRC-1:0]               src_ready,
  input  logic [NUM_SRC*HPOS_WIDTH-1:0]    src_hpos,
  input  logic [NUM_SRC*VPOS_WIDTH-1:0]    src_vpos,
  input  logic [NUM_SRC*RGB_WIDTH-1:0]     src_rgb,
  output logic [HPOS_WIDTH-1:0]            fb_hpos,
  output logic [VPOS_WIDTH-1:0]            fb_vpos,
  output logic [RGB_WIDTH-1:0]             fb_rgb,
  output logic                             fb_we,
  output logic [$clog2(DEPTH):0]           fifo_level,
  output logic                             fifo_full,
  output logic                             fifo_empty
`ifdef FB_WR_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]           hiwater,
  output logic [15:0]                      stall_cnt
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int RRW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int EW  = HPOS_WIDTH + VPOS_WIDTH + RGB_WIDTH;

  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  level;
  logic [RRW-1:0] rr, gidx, rr_next;
  logic           found, push, pop;
  logic [EW-1:0]  mem [DEPTH];
  logic [EW-1:0]  head, wdata;

  assign fifo_level = level;
  assign fifo_full  = (level == LW'(DEPTH));
  assign fifo_empty = (level == '0);

  // First valid source at or after rr, wrapping modulo NUM_SRC.
  always_comb begin
    int idx;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && src_valid[idx]) begin
        found = 1'b1;
        gidx  = RRW'(idx);
      end
    end
  end

  // Reset gating keeps ready low while reset is asserted.
  assign push      = found & ~fifo_full & reset_n;
  assign pop       = ~display_on & ~fifo_empty;
  assign src_ready = NUM_SRC'(push) << gidx;
  assign rr_next   = (gidx == RRW'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;

  assign wdata = {src_hpos[int'(gidx)*HPOS_WIDTH +: HPOS_WIDTH],
                  src_vpos[int'(gidx)*VPOS_WIDTH +: VPOS_WIDTH],
                  src_rgb[int'(gidx)*RGB_WIDTH +: RGB_WIDTH]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rr     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr     <= rr_next;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head    = mem[rd_ptr];
  assign fb_we   = pop;
  assign fb_hpos = display_on ? hpos : head[EW-1 -: HPOS_WIDTH];
  assign fb_vpos = display_on ? vpos : head[RGB_WIDTH +: VPOS_WIDTH];
  assign fb_rgb  = fifo_empty ? '0 : head[RGB_WIDTH-1:0];

`ifdef FB_WR_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hiwater   <= '0;
      stall_cnt <= '0;
    end else begin
      if (level > hiwater) hiwater <= level;
      if ((|src_valid) && fifo_full && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler: vector table, directed corners and a
// queue-based reference model under random traffic.
module tb_fb_write_scheduler;

  localparam int NS = 3;
  localparam int HW = 10;
  localparam int VW = 10;
  localparam int RW = 3;
  localparam int D  = 16;
  localparam int LW = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              display_on = 1'b1;
  logic [HW-1:0]     hpos = '0;
  logic [VW-1:0]     vpos = '0;
  logic [NS-1:0]     src_valid = '0;
  logic [NS-1:0]     src_ready;
  logic [NS*HW-1:0]  src_hpos = '0;
  logic [NS*VW-1:0]  src_vpos = '0;
  logic [NS*RW-1:0]  src_rgb = '0;
  logic [HW-1:0]     fb_hpos;
  logic [VW-1:0]     fb_vpos;
  logic [RW-1:0]     fb_rgb;
  logic              fb_we;
  logic [LW-1:0]     fifo_level;
  logic              fifo_full;
  logic              fifo_empty;
`ifdef FB_WR_STATS_EN
  logic [LW-1:0]     hiwater;
  logic [15:0]       stall_cnt;
`endif

  fb_write_scheduler #(
    .NUM_SRC(NS), .HPOS_WIDTH(HW), .VPOS_WIDTH(VW),
    .RGB_WIDTH(RW), .DEPTH(D)
  ) dut (
    .clk(clk), .reset_n(reset_n), .display_on(display_on),
    .hpos(hpos), .vpos(vpos),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_hpos(src_hpos), .src_vpos(src_vpos), .src_rgb(src_rgb),
    .fb_hpos(fb_hpos), .fb_vpos(fb_vpos), .fb_rgb(fb_rgb), .fb_we(fb_we),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
`ifdef FB_WR_STATS_EN
    , .hiwater(hiwater), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [RW-1:0] c;
  } pix_t;

  pix_t q[$];
  int   rr_m = 0;
  int   hw_m = 0;
  int   stall_m = 0;

  typedef struct {
    logic          disp;
    logic [NS-1:0] vld;
    logic [NS-1:0] rdy;
    int            lvl;
    logic          we;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_grant();
    int idx;
    if (q.size() == D) return -1;
    for (int k = 0; k < NS; k++) begin
      idx = (rr_m + k) % NS;
      if (src_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_check();
    int g;
    logic [NS-1:0] er;
    g  = m_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("src_ready", 32'(src_ready), 32'(er));
    chk("fb_we", 32'(fb_we), 32'(!display_on && q.size() != 0));
    chk("fifo_level", 32'(fifo_level), q.size());
    chk("fifo_full", 32'(fifo_full), 32'(q.size() == D));
    chk("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
    chk("fb_rgb", 32'(fb_rgb), (q.size() != 0) ? 32'(q[0].c) : 0);
    if (display_on) begin
      chk("fb_hpos_scan", 32'(fb_hpos), 32'(hpos));
      chk("fb_vpos_scan", 32'(fb_vpos), 32'(vpos));
    end else if (q.size() != 0) begin
      chk("fb_hpos_head", 32'(fb_hpos), 32'(q[0].h));
      chk("fb_vpos_head", 32'(fb_vpos), 32'(q[0].v));
    end
`ifdef FB_WR_STATS_EN
    chk("hiwater", 32'(hiwater), hw_m);
    chk("stall_cnt", 32'(stall_cnt), stall_m);
`endif
  endtask

  task automatic model_update();
    int g;
    pix_t p;
    g = m_grant();
    if (q.size() > hw_m) hw_m = q.size();
    if ((|src_valid) && q.size() == D && stall_m < 65535) stall_m++;
    if (!display_on && q.size() != 0) void'(q.pop_front());
    if (g >= 0) begin
      p.h = src_hpos[g*HW +: HW];
      p.v = src_vpos[g*VW +: VW];
      p.c = src_rgb[g*RW +: RW];
      q.push_back(p);
      rr_m = (g + 1) % NS;
    end
  endtask

  task automatic tick();
    #1 model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_data();
    src_hpos = (NS*HW)'($urandom);
    src_vpos = (NS*VW)'($urandom);
    src_rgb  = (NS*RW)'($urandom);
    hpos     = HW'($urandom);
    vpos     = VW'($urandom);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    display_on = 1'b0;
    src_valid  = '1;
    #1;
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_we", 32'(fb_we), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    src_valid = '0;
    q.delete();
    rr_m    = 0;
    hw_m    = 0;
    stall_m = 0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 3'b000, 3'b000, 0, 1'b0};
    tbl[1] = '{1'b1, 3'b111, 3'b001, 0, 1'b0};
    tbl[2] = '{1'b1, 3'b111, 3'b010, 1, 1'b0};
    tbl[3] = '{1'b1, 3'b111, 3'b100, 2, 1'b0};
    tbl[4] = '{1'b1, 3'b110, 3'b010, 3, 1'b0};
    tbl[5] = '{1'b1, 3'b011, 3'b001, 4, 1'b0};
    tbl[6] = '{1'b0, 3'b000, 3'b000, 5, 1'b1};
    tbl[7] = '{1'b0, 3'b100, 3'b100, 4, 1'b1};
    tbl[8] = '{1'b1, 3'b000, 3'b000, 4, 1'b0};

    do_reset();
    foreach (tbl[i]) begin
      display_on = tbl[i].disp;
      src_valid  = tbl[i].vld;
      rand_data();
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(src_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_level", i), 32'(fifo_level), tbl[i].lvl);
      chk($sformatf("tbl%0d_we", i), 32'(fb_we), 32'(tbl[i].we));
      tick();
    end

    // Fill with all sources valid during active video.
    do_reset();
    display_on = 1'b1;
    src_valid  = '1;
    for (int i = 0; i < D; i++) begin
      src_hpos = {HW'(3*i+2), HW'(3*i+1), HW'(3*i)};
      src_vpos = {VW'(100+i), VW'(200+i), VW'(300+i)};
      src_rgb  = (NS*RW)'($urandom);
      #1 chk("rr_order", 32'(src_ready), 32'(NS'(1) << (i % 3)));
      tick();
    end
    hpos = HW'(321);
    #1;
    chk("full_flag", 32'(fifo_full), 1);
    chk("full_ready", 32'(src_ready), 0);
    chk("full_we", 32'(fb_we), 0);
    chk("full_hpos_scan", 32'(fb_hpos), 321);

    // Drain in push order.
    display_on = 1'b0;
    src_valid  = '0;
    for (int i = 0; i < D; i++) begin
      #1;
      chk("drain_we", 32'(fb_we), 1);
      chk("drain_order", 32'(fb_hpos), 3*i + (i % 3));
      tick();
    end
    #1 chk("drain_empty", 32'(fifo_empty), 1);

    // Single entry latency.
    do_reset();
    display_on = 1'b0;
    src_valid  = 3'b010;
    src_hpos   = '0;
    src_vpos   = '0;
    src_rgb    = '0;
    src_hpos[HW +: HW] = HW'(5);
    src_vpos[VW +: VW] = VW'(7);
    src_rgb[RW +: RW]  = 3'b101;
    #1 chk("lat_ready", 32'(src_ready), 32'(3'b010));
    tick();
    src_valid = '0;
    #1;
    chk("lat_we", 32'(fb_we), 1);
    chk("lat_hpos", 32'(fb_hpos), 5);
    chk("lat_vpos", 32'(fb_vpos), 7);
    chk("lat_rgb", 32'(fb_rgb), 32'(3'b101));
    tick();

    // display_on rises mid-drain.
    do_reset();
    display_on = 1'b1;
    src_valid  = '1;
    repeat (4) begin rand_data(); tick(); end
    src_valid  = '0;
    display_on = 1'b0;
    tick();
    tick();
    display_on = 1'b1;
    #1;
    chk("mid_we", 32'(fb_we), 0);
    chk("mid_level", 32'(fifo_level), 2);
    tick();
    display_on = 1'b0;
    tick();
    tick();
    #1 chk("mid_empty", 32'(fifo_empty), 1);

    // Push and pop together at level 8, then asynchronous reset.
    do_reset();
    display_on = 1'b1;
    src_valid  = '1;
    repeat (8) begin rand_data(); tick(); end
    display_on = 1'b0;
    tick();
    #1 chk("pp_level", 32'(fifo_level), 8);
    reset_n = 1'b0;
    #1;
    chk("async_level", 32'(fifo_level), 0);
    chk("async_ready", 32'(src_ready), 0);
    chk("async_empty", 32'(fifo_empty), 1);

    // Random traffic against the reference model.
    do_reset();
    for (int p = 0; p < 40; p++) begin
      int len;
      display_on = p[0];
      len = $urandom_range(5, 30);
      for (int c = 0; c < len; c++) begin
        src_valid = NS'($urandom);
        rand_data();
        tick();
      end
    end

`ifdef FB_WR_STATS_EN
    do_reset();
    display_on = 1'b1;
    src_valid  = '1;
    repeat (D) begin rand_data(); tick(); end
    src_valid = 3'b001;
    repeat (10) tick();
    src_valid = '0;
    #1;
    chk("stall_cnt_10", 32'(stall_cnt), 10);
    chk("hiwater_full", 32'(hiwater), D);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
